// File: rtl/esm_uart_pkg.sv
// Shared UART definitions: receive FSM state encoding and bit-period helper.
// Used by both the RX front end and the TX block.
package esm_uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_HIGH = 3'd4
    } uart_rx_state_t;

    // Rounded clock cycles per serial bit.
    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/esm_uart_rx_if.sv
// Received-byte stream plus line-status pulses between the UART RX and its consumer.
interface esm_uart_rx_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       break_det;
    logic       overrun;

    modport master (
        output rx_data, rx_valid, frame_err, break_det, overrun,
        input  rx_ready
    );

    modport slave (
        input  rx_data, rx_valid, frame_err, break_det, overrun,
        output rx_ready
    );
endinterface

// File: rtl/esm_byte_fifo.sv
// First-word-fall-through byte FIFO with a registered head byte that holds its
// value while empty; pointers carry an extra wrap bit for full/empty.
module esm_byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push_i,
    input  logic [7:0] push_data_i,
    output logic       full_o,
    input  logic       pop_i,
    output logic       empty_o,
    output logic [7:0] dout_o
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_q, wr_d;
    logic [AW:0] rd_q, rd_d;
    logic [7:0]  dout_q, dout_d;
    logic        empty, full, do_push, do_pop;

    assign empty   = (wr_q == rd_q);
    assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_pop  = pop_i & ~empty;
    assign do_push = push_i & (~full | do_pop);

    // The head register is loaded from the slot the read pointer lands on,
    // bypassing the RAM when that slot is the one being written right now.
    always_comb begin
        wr_d   = wr_q + {{AW{1'b0}}, do_push};
        rd_d   = rd_q + {{AW{1'b0}}, do_pop};
        dout_d = dout_q;
        if (rd_d != wr_d) begin
            if (do_push && (rd_d[AW-1:0] == wr_q[AW-1:0])) begin
                dout_d = push_data_i;
            end else begin
                dout_d = mem[rd_d[AW-1:0]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_q[AW-1:0]] <= push_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q   <= '0;
            rd_q   <= '0;
            dout_q <= 8'h00;
        end else begin
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            dout_q <= dout_d;
        end
    end

    assign full_o  = full;
    assign empty_o = empty;
    assign dout_o  = dout_q;
endmodule

// File: rtl/esm_uart_rx.sv
// 8N1 UART receiver: 2-FF synchronizer, centre-sampling deframer FSM, status
// pulses, and a byte FIFO feeding a valid/ready stream.
module esm_uart_rx
    import esm_uart_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rx,
    esm_uart_rx_if.master rx_if
);
    localparam int CPB = clks_per_bit(CLK_HZ, BAUD);
    localparam int CW  = $clog2(CPB);
    localparam logic [CW-1:0] FULL_M1 = CW'(CPB - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(CPB / 2 - 1);

    logic           sync1_q, sync2_q, prev_q;
    logic           line, fall;
    uart_rx_state_t state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2:0]     idx_q, idx_d;
    logic [7:0]     shift_q, shift_d;
    logic           frame_q, frame_d;
    logic           break_q, break_d;
    logic           ovr_q, ovr_d;
    logic           push;
    logic           fifo_full, fifo_empty;
    logic [7:0]     fifo_dout;

    assign line = sync2_q;
    assign fall = prev_q & ~sync2_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        shift_d = shift_q;
        push    = 1'b0;
        frame_d = 1'b0;
        break_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (fall) state_d = ST_START;
            end
            ST_START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d   = '0;
                    state_d = line ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    shift_d = {line, shift_q[7:1]};
                    idx_d   = idx_q + 1'b1;
                    if (idx_q == 3'd7) state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d = '0;
                    if (line) begin
                        push    = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        frame_d = 1'b1;
                        break_d = (shift_q == 8'h00);
                        state_d = ST_WAIT_HIGH;
                    end
                end
            end
            ST_WAIT_HIGH: begin
                cnt_d = '0;
                if (line) state_d = ST_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
        // Full FIFO only loses the byte when the consumer is not popping this cycle.
        ovr_d = push & fifo_full & ~rx_if.rx_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= 8'h00;
            frame_q <= 1'b0;
            break_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            sync1_q <= rx;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            frame_q <= frame_d;
            break_q <= break_d;
            ovr_q   <= ovr_d;
        end
    end

    esm_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .push_data_i (shift_q),
        .full_o      (fifo_full),
        .pop_i       (rx_if.rx_ready),
        .empty_o     (fifo_empty),
        .dout_o      (fifo_dout)
    );

    assign rx_if.rx_data   = fifo_dout;
    assign rx_if.rx_valid  = ~fifo_empty;
    assign rx_if.frame_err = frame_q;
    assign rx_if.break_det = break_q;
    assign rx_if.overrun   = ovr_q;
endmodule

// File: tb/tb_esm_uart_rx.sv
// Scoreboard bench for esm_uart_rx at a reduced bit period (16 clocks per bit).
module tb_esm_uart_rx;
    import esm_uart_pkg::*;

    localparam int CLK_HZ = 1_600_000;
    localparam int BAUD   = 100_000;
    localparam int CPB    = 16;                   // (1_600_000 + 50_000) / 100_000
    localparam int HALF   = 8;
    localparam int LAT    = HALF + 9 * CPB + 3;   // start edge to rx_valid

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx  = 1'b1;

    esm_uart_rx_if bus ();

    esm_uart_rx #(
        .CLK_HZ     (CLK_HZ),
        .BAUD       (BAUD),
        .FIFO_DEPTH (16)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .rx    (rx),
        .rx_if (bus)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         start_cyc = 0;
    int         rise_cyc = -1;
    int         cnt_rise = 0;
    int         cnt_frame = 0;
    int         cnt_break = 0;
    int         cnt_ovr = 0;
    int         cnt_break_alone = 0;
    logic       valid_prev = 1'b0;
    logic [7:0] exp_b;
    logic [7:0] sb[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every accepted byte and tallies status pulses.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.frame_err) cnt_frame++;
            if (bus.break_det) cnt_break++;
            if (bus.overrun) cnt_ovr++;
            if (bus.break_det && !bus.frame_err) cnt_break_alone++;
            if (bus.rx_valid && !valid_prev) begin
                rise_cyc = cyc;
                cnt_rise++;
            end
            if (bus.rx_valid && bus.rx_ready) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_byte: got 0x%02h required no byte", bus.rx_data);
                end else begin
                    exp_b = sb.pop_front();
                    $display("rx byte 0x%02h expected 0x%02h at cycle %0d", bus.rx_data, exp_b, cyc);
                    check("rx_byte", int'(bus.rx_data), int'(exp_b));
                end
            end
        end
        valid_prev = bus.rx_valid;
    end

    task automatic drive_bit(input logic b);
        @(posedge clk);
        #1 rx = b;
        repeat (CPB - 1) @(posedge clk);
    endtask

    task automatic idle_bits(input int n);
        for (int i = 0; i < n; i++) drive_bit(1'b1);
    endtask

    // Sends one frame; rst_bit >= 0 pulses rst for one cycle mid-way through that data bit.
    task automatic send_frame(input logic [7:0] d, input logic stop, input int rst_bit);
        @(posedge clk);
        #1 rx = 1'b0;
        start_cyc = cyc;
        repeat (CPB - 1) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            if (i == rst_bit) begin
                @(posedge clk);
                #1 rx = d[i];
                repeat (HALF - 1) @(posedge clk);
                #1 rst = 1'b1;
                sb.delete();
                @(posedge clk);
                #1 rst = 1'b0;
                repeat (CPB - HALF - 1) @(posedge clk);
            end else begin
                drive_bit(d[i]);
            end
        end
        drive_bit(stop);
    endtask

    task automatic expect_drained(input string name, input int budget);
        int n;
        n = 0;
        while ((sb.size() != 0 || bus.rx_valid) && n < budget) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (sb.size() != 0 || bus.rx_valid) begin
            bad++;
            $display("FAIL %s: pending=%0d rx_valid=%0b required pending=0 rx_valid=0",
                     name, sb.size(), bus.rx_valid);
        end
    endtask

    initial begin
        int f0, b0, r0, lat;
        bus.rx_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_rx_valid", int'(bus.rx_valid), 0);
        check("reset_rx_data", int'(bus.rx_data), 0);
        check("reset_flags", int'({bus.frame_err, bus.break_det, bus.overrun}), 0);

        // 1: single byte, latency from start edge
        sb.push_back(8'h55);
        send_frame(8'h55, 1'b1, -1);
        idle_bits(2);
        expect_drained("t1_drain", 50);
        lat = rise_cyc - start_cyc;
        total++;
        if (lat < LAT - 2 || lat > LAT + 2) begin
            bad++;
            $display("FAIL t1_latency: got %0d cycles required %0d +/-2", lat, LAT);
        end
        check("t1_frame_err", cnt_frame, 0);
        check("t1_overrun", cnt_ovr, 0);

        // 2: short low glitch is a false start
        r0 = cnt_rise;
        @(posedge clk);
        #1 rx = 1'b0;
        repeat (4) @(posedge clk);
        #1 rx = 1'b1;
        idle_bits(3);
        check("t2_no_valid", cnt_rise - r0, 0);
        check("t2_no_flags", cnt_frame + cnt_break + cnt_ovr, 0);
        check("t2_fsm_idle", int'(dut.state_q), int'(ST_IDLE));

        // 3: framing error discards the byte, next byte still received
        send_frame(8'hA3, 1'b0, -1);
        check("t3_frame_err", cnt_frame, 1);
        idle_bits(2);
        sb.push_back(8'h41);
        send_frame(8'h41, 1'b1, -1);
        idle_bits(2);
        expect_drained("t3_drain", 50);
        check("t3_frame_total", cnt_frame, 1);
        check("t3_no_break", cnt_break, 0);

        // 4: 17 back-to-back bytes into a 16-deep FIFO with the consumer stalled
        @(posedge clk);
        #1 bus.rx_ready = 1'b0;
        for (int b = 0; b <= 16; b++) begin
            if (b < 16) sb.push_back(8'(b));
            send_frame(8'(b), 1'b1, -1);
            if (b == 15) check("t4_no_overrun_16", cnt_ovr, 0);
        end
        check("t4_overrun_17", cnt_ovr, 1);
        @(posedge clk);
        #1 bus.rx_ready = 1'b1;
        expect_drained("t4_drain", 100);
        check("t4_overrun_total", cnt_ovr, 1);

        // 5: line held low for 20 bit times = break
        f0 = cnt_frame;
        b0 = cnt_break;
        @(posedge clk);
        #1 rx = 1'b0;
        repeat (20 * CPB) @(posedge clk);
        #1 rx = 1'b1;
        idle_bits(2);
        check("t5_frame_err", cnt_frame - f0, 1);
        check("t5_break_det", cnt_break - b0, 1);
        sb.push_back(8'h0D);
        send_frame(8'h0D, 1'b1, -1);
        idle_bits(2);
        expect_drained("t5_drain", 50);

        // 6: reset mid-byte with three bytes queued
        @(posedge clk);
        #1 bus.rx_ready = 1'b0;
        for (int b = 0; b < 3; b++) begin
            sb.push_back(8'h31 + 8'(b));
            send_frame(8'h31 + 8'(b), 1'b1, -1);
        end
        @(negedge clk);
        check("t6_queued_valid", int'(bus.rx_valid), 1);
        send_frame(8'hF0, 1'b1, 4);
        @(negedge clk);
        check("t6_reset_valid", int'(bus.rx_valid), 0);
        check("t6_reset_data", int'(bus.rx_data), 0);
        check("t6_reset_flags", int'({bus.frame_err, bus.break_det, bus.overrun}), 0);
        @(posedge clk);
        #1 bus.rx_ready = 1'b1;
        idle_bits(2);
        expect_drained("t6_empty", 10);
        sb.push_back(8'h7E);
        send_frame(8'h7E, 1'b1, -1);
        idle_bits(2);
        expect_drained("t6_drain", 50);

        check("break_without_frame_err", cnt_break_alone, 0);
        check("final_frame_total", cnt_frame, 2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
